// File: rtl/mem_pkg.sv
// Shared definitions for the memory-access stage: funct3 encodings,
// FSM state type and the store byte-enable helper.
package mem_pkg;

  localparam logic [2:0] F3_LB  = 3'd0;
  localparam logic [2:0] F3_LH  = 3'd1;
  localparam logic [2:0] F3_LW  = 3'd2;
  localparam logic [2:0] F3_LBU = 3'd4;
  localparam logic [2:0] F3_LHU = 3'd5;

  localparam logic [2:0] F3_SB  = 3'd0;
  localparam logic [2:0] F3_SH  = 3'd1;
  localparam logic [2:0] F3_SW  = 3'd2;

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } state_t;

  function automatic logic [3:0] store_be(input logic [2:0] funct3, input logic [1:0] off);
    logic [3:0] be;
    case (funct3)
      F3_SB:   be = 4'b0001 << off;
      F3_SH:   be = off[1] ? 4'b1100 : 4'b0011;
      default: be = 4'b1111;
    endcase
    return be;
  endfunction

endpackage

// File: rtl/mem_load_align.sv
// Picks the addressed byte/halfword out of a fetched word and extends it
// according to the load flavour.
module mem_load_align
  import mem_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] rdata,
  input  logic [1:0]      addr,
  input  logic [2:0]      funct3,
  output logic [XLEN-1:0] result
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = rdata[7:0];
    case (addr)
      2'd0:    byte_sel = rdata[7:0];
      2'd1:    byte_sel = rdata[15:8];
      2'd2:    byte_sel = rdata[23:16];
      default: byte_sel = rdata[31:24];
    endcase
    half_sel = addr[1] ? rdata[31:16] : rdata[15:0];

    case (funct3)
      F3_LB:   result = {{(XLEN-8){byte_sel[7]}}, byte_sel};
      F3_LH:   result = {{(XLEN-16){half_sel[15]}}, half_sel};
      F3_LBU:  result = {{(XLEN-8){1'b0}}, byte_sel};
      F3_LHU:  result = {{(XLEN-16){1'b0}}, half_sel};
      default: result = rdata;
    endcase
  end

endmodule

// File: rtl/mem_access_stage.sv
// Pipeline memory stage: passes ALU results through in one cycle and runs
// loads/stores against a ready-handshaked data memory, stalling upstream meanwhile.
module mem_access_stage
  import mem_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5
) (
  input  logic              CLK,
  input  logic              rst,
  input  logic              ex_valid,
  input  logic              ex_mem_read,
  input  logic              ex_mem_write,
  input  logic [2:0]        ex_funct3,
  input  logic [XLEN-1:0]   ex_alu_result,
  input  logic [XLEN-1:0]   ex_store_data,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic              ex_reg_write,
  input  logic              ex_wb_sel,
  input  logic              flush,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [XLEN-1:0]   dmem_addr,
  output logic [3:0]        dmem_be,
  output logic [XLEN-1:0]   dmem_wdata,
  input  logic [XLEN-1:0]   dmem_rdata,
  input  logic              dmem_ready,
  output logic              stall_o,
  output logic              wb_valid,
  output logic [REG_AW-1:0] wb_rd,
  output logic              wb_reg_write,
  output logic [XLEN-1:0]   wb_data,
  output logic              misalign_o
);

  state_t state, state_next;

  logic              is_mem, load_ok, store_ok, misaligned, illegal, fault;
  logic              accept, start_access;
  logic [XLEN-1:0]   store_wdata;
  logic [XLEN-1:0]   load_result;

  logic [2:0]        op_funct3;
  logic [1:0]        op_off;
  logic [REG_AW-1:0] op_rd;
  logic              op_reg_write;
  logic              op_wb_sel;
  logic [XLEN-1:0]   op_alu;

  always_comb begin
    is_mem   = ex_mem_read | ex_mem_write;
    load_ok  = (ex_funct3 == F3_LB) || (ex_funct3 == F3_LH) || (ex_funct3 == F3_LW) ||
               (ex_funct3 == F3_LBU) || (ex_funct3 == F3_LHU);
    store_ok = (ex_funct3 == F3_SB) || (ex_funct3 == F3_SH) || (ex_funct3 == F3_SW);
    // funct3[1:0] gives the access size for both loads and stores
    misaligned = ((ex_funct3[1:0] == 2'b01) && ex_alu_result[0]) ||
                 ((ex_funct3[1:0] == 2'b10) && (ex_alu_result[1:0] != 2'b00));
    illegal  = (ex_mem_read & ex_mem_write) | (ex_mem_read & ~load_ok) |
               (ex_mem_write & ~store_ok);
    fault        = is_mem & (illegal | misaligned);
    accept       = (state == IDLE) & ex_valid & ~flush;
    start_access = accept & is_mem & ~fault;

    case (ex_funct3)
      F3_SB:   store_wdata = {(XLEN/8){ex_store_data[7:0]}};
      F3_SH:   store_wdata = {(XLEN/16){ex_store_data[15:0]}};
      default: store_wdata = ex_store_data;
    endcase
  end

  always_ff @(posedge CLK or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:   if (start_access) state_next = ACCESS;
      ACCESS: if (dmem_ready)   state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    stall_o  = (state == ACCESS);
    dmem_req = (state == ACCESS);
  end

  mem_load_align #(.XLEN(XLEN)) u_load_align (
    .rdata  (dmem_rdata),
    .addr   (op_off),
    .funct3 (op_funct3),
    .result (load_result)
  );

  // Request fields are loaded only on entry to ACCESS so they stay put until ready.
  always_ff @(posedge CLK or negedge rst) begin
    if (!rst) begin
      dmem_we      <= 1'b0;
      dmem_addr    <= '0;
      dmem_be      <= 4'b0000;
      dmem_wdata   <= '0;
      wb_valid     <= 1'b0;
      wb_rd        <= '0;
      wb_reg_write <= 1'b0;
      wb_data      <= '0;
      misalign_o   <= 1'b0;
      op_funct3    <= 3'd0;
      op_off       <= 2'd0;
      op_rd        <= '0;
      op_reg_write <= 1'b0;
      op_wb_sel    <= 1'b0;
      op_alu       <= '0;
    end else begin
      case (state)
        IDLE: begin
          wb_valid     <= accept & (~is_mem | fault);
          wb_reg_write <= accept & ~is_mem & ex_reg_write;
          misalign_o   <= accept & fault;
          if (accept & (~is_mem | fault)) begin
            wb_rd   <= ex_rd;
            wb_data <= ex_alu_result;
          end
          if (start_access) begin
            dmem_we      <= ex_mem_write;
            dmem_addr    <= {ex_alu_result[XLEN-1:2], 2'b00};
            dmem_be      <= ex_mem_write ? store_be(ex_funct3, ex_alu_result[1:0]) : 4'b1111;
            dmem_wdata   <= store_wdata;
            op_funct3    <= ex_funct3;
            op_off       <= ex_alu_result[1:0];
            op_rd        <= ex_rd;
            op_reg_write <= ex_reg_write;
            op_wb_sel    <= ex_wb_sel;
            op_alu       <= ex_alu_result;
          end
        end
        ACCESS: begin
          misalign_o   <= 1'b0;
          wb_valid     <= dmem_ready;
          wb_reg_write <= dmem_ready & ~dmem_we & op_reg_write;
          if (dmem_ready) begin
            wb_rd   <= op_rd;
            wb_data <= op_wb_sel ? load_result : op_alu;
          end
        end
        default: begin
          wb_valid     <= 1'b0;
          wb_reg_write <= 1'b0;
          misalign_o   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/mem_access_stage.md
MEM_ACCESS_STAGE -- requirements
Module: mem_access_stage

Interface
REQ-001 SHALL have parameter XLEN, default 32, datapath width.
REQ-002 SHALL have parameter REG_AW, default 5, register-index width.
REQ-003 SHALL have ports: CLK  in  1  rising-edge clock.
REQ-004 SHALL have ports: rst  in  1  asynchronous, active-low reset (low = reset asserted).
REQ-005 SHALL have ports: ex_valid in 1, ex_mem_read in 1, ex_mem_write in 1, ex_funct3 in 3, ex_alu_result in XLEN (address or ALU value), ex_store_data in XLEN, ex_rd in REG_AW, ex_reg_write in 1, ex_wb_sel in 1 (1 = memory data, 0 = ALU result), flush in 1.
REQ-006 SHALL have ports: dmem_req out 1, dmem_we out 1, dmem_addr out XLEN (word-aligned, [1:0]=0), dmem_be out 4, dmem_wdata out XLEN, dmem_rdata in XLEN, dmem_ready in 1.
REQ-007 SHALL have ports: stall_o out 1 (upstream holds ex_* stable), wb_valid out 1, wb_rd out REG_AW, wb_reg_write out 1, wb_data out XLEN, misalign_o out 1.

Function
REQ-008 SHALL implement FSM states IDLE and ACCESS; stall_o = (state==ACCESS).
REQ-009 In IDLE, with ex_valid=1 and flush=0, SHALL capture the op at the clock edge; a non-memory op (read=write=0) SHALL appear on wb_* after that edge (1-cycle latency), wb_data=ex_alu_result.
REQ-010 In IDLE, an aligned, legal memory op SHALL be captured and the FSM SHALL move to ACCESS; wb_valid=0 in the following cycle.
REQ-011 In ACCESS, dmem_req=1 with dmem_addr/be/we/wdata held constant until the cycle dmem_ready=1; at that edge, wb_* SHALL be loaded and the FSM SHALL return to IDLE. Minimum memory-op latency: 2 cycles.
REQ-012 dmem_req SHALL be 0 in IDLE; dmem_ready outside ACCESS SHALL be ignored.
REQ-013 Loads: dmem_we=0, dmem_be=4'b1111; funct3 0=LB, 1=LH, 2=LW, 4=LBU, 5=LHU; byte lane addr[1:0], half lane addr[1]; LB/LH sign-extend, LBU/LHU zero-extend.
REQ-014 Stores: dmem_we=1; SB be=1<<addr[1:0], wdata=byte replicated x4; SH be=0011 (addr[1]=0) / 1100 (addr[1]=1), wdata=half replicated x2; SW be=1111; funct3 0/1/2 only; wb_reg_write=0.
REQ-015 Misaligned (halfword addr[0]=1, word addr[1:0]!=0) or illegal funct3 SHALL issue no request, stay IDLE, give wb_valid=1, wb_reg_write=0, misalign_o=1 for exactly one cycle.
REQ-016 ex_mem_read and ex_mem_write both 1 SHALL be treated as illegal (REQ-015).
REQ-017 flush=1 in IDLE SHALL drop the input (wb_valid=0 next cycle); flush during ACCESS SHALL be ignored (the transaction completes).
REQ-018 ex_valid=0 in IDLE SHALL produce wb_valid=0 next cycle; wb_rd/wb_data may hold.
REQ-019 wb_reg_write SHALL be 0 whenever wb_valid=0.

Reset
REQ-020 rst low SHALL asynchronously force state=IDLE, dmem_req=0, dmem_we=0, dmem_be=0, dmem_addr=0, dmem_wdata=0, wb_valid=0, wb_reg_write=0, wb_rd=0, wb_data=0, misalign_o=0, stall_o=0.
REQ-021 Reset asserted during ACCESS SHALL abandon the transaction with no writeback; operation SHALL resume in IDLE on the first edge after rst rises.

Structure
REQ-022 Shared package mem_pkg SHALL hold the funct3 load/store localparams and the IDLE/ACCESS state encoding.
REQ-023 Load extraction SHALL be a combinational sub-module mem_load_align (rdata, addr[1:0], funct3 -> XLEN result); the top holds the FSM and registers.

Verification (memory word0=0x56783412, word1=0x9ABCDEF0, dmem_ready=1 on first ACCESS cycle unless stated)
REQ-024 LB addr 0x1 -> be 1111, wb_data=0x00000034, wb_valid 2 cycles after capture.
REQ-025 LH addr 0x6 -> wb_data=0xFFFF9ABC; LHU addr 0x6 -> 0x00009ABC; LW addr 0x4 -> 0x9ABCDEF0.
REQ-026 SB data 0x000000AB addr 0x2 -> dmem_we=1, be=0100, wdata=0xABABABAB, addr=0x0, wb_reg_write=0.
REQ-027 LW addr 0x2 -> no dmem_req, misalign_o=1 for one cycle, wb_reg_write=0; SH addr 0x3 -> same.
REQ-028 LW with dmem_ready delayed 3 cycles -> stall_o high 4 cycles, request signals stable throughout, single wb_valid pulse; flush during stall has no effect.
REQ-029 rst low mid-ACCESS -> dmem_req and stall_o drop without a clock edge, no wb_valid; the next LW after release completes normally.
